// File: rtl/mp3dec_i2s_tx_pkg.sv
// Shared definitions for the MP3 decoder I2S transmitter: states, slot geometry, PCM word layout.
package mp3dec_i2s_tx_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } i2s_state_e;

  localparam int unsigned SLOT_HALF    = 16;
  localparam int unsigned SLOT_NUM     = 32;
  localparam int unsigned SLOT_W       = $clog2(SLOT_NUM);
  localparam int unsigned WORD_W       = 32;
  localparam int unsigned BCLK_DIV_DEF = 8;

  typedef struct packed {
    logic [15:0] left;
    logic [15:0] right;
  } pcm_word_t;

endpackage

// File: rtl/mp3dec_bclk_gen.sv
// Bit-clock divider: toggles BCLK every BCLK_DIV cycles while running and flags each falling edge.
module mp3dec_bclk_gen #(
  parameter int unsigned BCLK_DIV = 8,
  parameter int unsigned CNT_W    = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic run_i,
  output logic bclk_o,
  output logic fall_evt_c
);

  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(BCLK_DIV - 1);

  logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
  logic             bclk_q, bclk_d;
  logic             tc;

  always_comb begin
    div_cnt_d = div_cnt_q;
    bclk_d    = bclk_q;
    tc        = run_i && (div_cnt_q == DIV_LAST);
    if (!run_i) begin
      div_cnt_d = '0;
      bclk_d    = 1'b0;
    end else if (tc) begin
      div_cnt_d = '0;
      bclk_d    = ~bclk_q;
    end else begin
      div_cnt_d = div_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q <= '0;
      bclk_q    <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      bclk_q    <= bclk_d;
    end
  end

  assign bclk_o     = bclk_q;
  assign fall_evt_c = tc && bclk_q;

endmodule

// File: rtl/mp3dec_i2s_tx.sv
// I2S master transmitter: prefetches one stereo word from the PCM FIFO and shifts it out MSB first.
module mp3dec_i2s_tx
  import mp3dec_i2s_tx_pkg::*;
#(
  parameter int unsigned BCLK_DIV = BCLK_DIV_DEF,
  parameter int unsigned CNT_W    = 8
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Enable,
  input  logic              fifo_empty,
  output logic              fifo_ren,
  input  logic [WORD_W-1:0] fifo_datain,
  output logic              i2s_bclk,
  output logic              i2s_lrck,
  output logic              i2s_sdata,
  output logic              underrun,
  output logic              busy
);

  i2s_state_e        state_q, state_d;
  logic [SLOT_W-1:0] slot_q, slot_d, slot_nx;
  logic [WORD_W-1:0] shreg_q, shreg_d;
  pcm_word_t         hold_q, hold_d;
  logic              hold_valid_q, hold_valid_d;
  logic              ren_q, ren_d;
  logic              rd_pend_q, rd_pend_d;
  logic              lrck_q, lrck_d;
  logic              und_q, und_d;
  logic              busy_q, busy_d;
  logic              fall_evt;
  logic              frame_ld;

  mp3dec_bclk_gen #(
    .BCLK_DIV(BCLK_DIV),
    .CNT_W   (CNT_W)
  ) u_bclk_gen (
    .clk       (Clk),
    .rst       (Rst),
    .run_i     (state_q != S_IDLE),
    .bclk_o    (i2s_bclk),
    .fall_evt_c(fall_evt)
  );

  always_comb begin
    state_d      = state_q;
    slot_d       = slot_q;
    shreg_d      = shreg_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    lrck_d       = lrck_q;
    und_d        = 1'b0;
    rd_pend_d    = ren_q;
    slot_nx      = slot_q + SLOT_W'(1);
    frame_ld     = fall_evt && (slot_nx == SLOT_W'(1));
    // At most one read in flight; stopped idle does not prefetch.
    ren_d        = !fifo_empty && !hold_valid_q && !ren_q && !rd_pend_q &&
                   !((state_q == S_IDLE) && !Enable);

    case (state_q)
      S_IDLE:  if (Enable) state_d = S_RUN;
      S_RUN:   if (!Enable) state_d = S_DRAIN;
      S_DRAIN: begin
        if (Enable)        state_d = S_RUN;
        else if (frame_ld) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (fall_evt) begin
      slot_d  = slot_nx;
      lrck_d  = (slot_nx >= SLOT_W'(SLOT_HALF));
      shreg_d = {shreg_q[WORD_W-2:0], 1'b0};
    end

    // Frame boundary: stop cleanly, load the held word, or send a silent frame.
    if (frame_ld) begin
      if (state_d == S_IDLE) begin
        slot_d  = '0;
        lrck_d  = 1'b0;
        shreg_d = '0;
      end else if (hold_valid_q) begin
        shreg_d      = hold_q;
        hold_valid_d = 1'b0;
      end else begin
        shreg_d = '0;
        und_d   = 1'b1;
      end
    end

    if (rd_pend_q) begin
      hold_d       = fifo_datain;
      hold_valid_d = 1'b1;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q      <= S_IDLE;
      slot_q       <= '0;
      shreg_q      <= '0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      ren_q        <= 1'b0;
      rd_pend_q    <= 1'b0;
      lrck_q       <= 1'b0;
      und_q        <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      slot_q       <= slot_d;
      shreg_q      <= shreg_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      ren_q        <= ren_d;
      rd_pend_q    <= rd_pend_d;
      lrck_q       <= lrck_d;
      und_q        <= und_d;
      busy_q       <= busy_d;
    end
  end

  assign fifo_ren  = ren_q;
  assign i2s_lrck  = lrck_q;
  assign i2s_sdata = shreg_q[WORD_W-1];
  assign underrun  = und_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mp3dec_i2s_tx.sv
// Scoreboard bench for mp3dec_i2s_tx: a monitor decodes I2S frames and checks them against queued words.
module tb_mp3dec_i2s_tx;

  localparam int unsigned DIV = 2;

  logic        clk = 1'b0;
  logic        Rst;
  logic        Enable;
  logic        fifo_empty = 1'b1;
  logic        fifo_ren;
  logic [31:0] fifo_datain = '0;
  logic        i2s_bclk, i2s_lrck, i2s_sdata, underrun, busy;

  mp3dec_i2s_tx #(.BCLK_DIV(DIV), .CNT_W(8)) dut (
    .Clk        (clk),
    .Rst        (Rst),
    .Enable     (Enable),
    .fifo_empty (fifo_empty),
    .fifo_ren   (fifo_ren),
    .fifo_datain(fifo_datain),
    .i2s_bclk   (i2s_bclk),
    .i2s_lrck   (i2s_lrck),
    .i2s_sdata  (i2s_sdata),
    .underrun   (underrun),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Producer side (written only by the stimulus process)
  logic [31:0] push_w [0:31];
  int          push_cnt = 0;
  logic [31:0] exp_w [0:63];
  logic        exp_u [0:63];
  int          exp_wr = 0;
  string       snap_name = "";
  logic [5:0]  snap_exp = '0;
  int          snap_req = 0;
  bit          done_req = 1'b0;
  int          timeouts = 0;

  // FIFO model: pops on the cycle fifo_ren is high so data is valid the next cycle
  int rd_idx = 0;
  always @(negedge clk) begin
    #2;
    if (fifo_ren && rd_idx < push_cnt) begin
      fifo_datain = push_w[rd_idx];
      rd_idx++;
    end
    fifo_empty = (rd_idx >= push_cnt);
  end

  // Monitor / checker (sole owner of the counts)
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          snap_ack = 0;
  int          exp_rd = 0;
  int          ren_seen = 0;
  int          last_ren = -100;
  int          last_rise = -1;
  int          hi_cnt = 0;
  logic [31:0] acc = '0;
  logic        bclk_prev = 1'b0;
  logic        lrck_prev = 1'b0;
  logic        und_seen = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    #1;
    cyc++;
    if (snap_req != snap_ack) begin
      chk(snap_name, 32'({busy, i2s_bclk, i2s_lrck, i2s_sdata, fifo_ren, underrun}), 32'(snap_exp));
      snap_ack = snap_req;
    end
    if (Rst) begin
      last_rise = -1;
      hi_cnt    = 0;
      bclk_prev = 1'b0;
      lrck_prev = 1'b0;
      und_seen  = 1'b0;
    end else begin
      if (fifo_ren) begin
        ren_seen++;
        chk("ren_while_empty", 32'(fifo_empty), 32'd0);
        chk("ren_spacing_ok", 32'((cyc - last_ren) >= 2), 32'd1);
        last_ren = cyc;
      end
      if (underrun) und_seen = 1'b1;
      if (i2s_bclk && !bclk_prev) begin
        if (last_rise >= 0) chk("bclk_period", 32'(cyc - last_rise), 32'(2 * DIV));
        last_rise = cyc;
        acc = {acc[30:0], i2s_sdata};
        if (i2s_lrck) hi_cnt++;
        if (!i2s_lrck && lrck_prev) begin
          if (exp_rd >= exp_wr) begin
            chk("unexpected_frame", acc, 32'hxxxx_xxxx);
          end else begin
            chk("frame_word", acc, exp_w[exp_rd]);
            chk("frame_underrun", 32'(und_seen), 32'(exp_u[exp_rd]));
            chk("lrck_high_slots", 32'(hi_cnt), 32'd16);
            exp_rd++;
          end
          und_seen = 1'b0;
          hi_cnt   = 0;
        end
        lrck_prev = i2s_lrck;
      end
      bclk_prev = i2s_bclk;
      if (!busy) last_rise = -1;
    end
    if (done_req || cyc > 50000) begin
      chk("watchdog_ok", 32'(cyc <= 50000), 32'd1);
      chk("frames_outstanding", 32'(exp_wr - exp_rd), 32'd0);
      chk("fifo_reads", 32'(ren_seen), 32'(push_cnt));
      chk("wait_timeouts", 32'(timeouts), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
    end
  end

  task automatic push(input logic [31:0] w);
    push_w[push_cnt] = w;
    push_cnt++;
  endtask

  task automatic sb(input logic [31:0] w, input logic u);
    exp_w[exp_wr] = w;
    exp_u[exp_wr] = u;
    exp_wr++;
  endtask

  // busy, bclk, lrck, sdata, fifo_ren, underrun
  task automatic snap(input string nm, input logic [5:0] e);
    snap_name = nm;
    snap_exp  = e;
    snap_req++;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (busy) timeouts++;
    repeat (4) @(negedge clk);
  endtask

  // Frame loads land 4 + 128*k cycles after enable; disabling 16 cycles past the last wanted load yields N frames.
  task automatic run_frames(input int n);
    Enable = 1'b1;
    repeat (20 + 128 * (n - 1)) @(negedge clk);
    Enable = 1'b0;
    wait_idle();
  endtask

  initial begin
    Rst    = 1'b1;
    Enable = 1'b0;
    repeat (3) @(negedge clk);
    snap("reset_outputs", 6'b000000);
    @(negedge clk);
    Rst = 1'b0;
    repeat (3) @(negedge clk);
    snap("idle_outputs", 6'b000000);
    @(negedge clk);

    // Single preloaded word
    push(32'hA5A5_3C3C);
    sb(32'hA5A5_3C3C, 1'b0);
    run_frames(1);

    // Empty FIFO: three silent frames
    sb(32'h0, 1'b1); sb(32'h0, 1'b1); sb(32'h0, 1'b1);
    run_frames(3);

    // Three words then underrun
    push(32'h0000_0001); push(32'h0000_0002); push(32'h0000_0003);
    sb(32'h0000_0001, 1'b0); sb(32'h0000_0002, 1'b0); sb(32'h0000_0003, 1'b0); sb(32'h0, 1'b1);
    run_frames(4);

    // Disable at slot 20: right LSB finishes, then everything drops at the slot-1 fall
    push(32'h1234_8001);
    sb(32'h1234_8001, 1'b0);
    Enable = 1'b1;
    repeat (82) @(negedge clk);
    Enable = 1'b0;
    repeat (50) @(negedge clk);
    snap("drain_last_slot", 6'b110100);
    @(negedge clk);
    snap("drain_stopped", 6'b000000);
    wait_idle();

    // Re-enable during drain: second frame follows with no gap
    push(32'h0F0F_F0F0); push(32'h8000_0001);
    sb(32'h0F0F_F0F0, 1'b0); sb(32'h8000_0001, 1'b0);
    Enable = 1'b1;
    repeat (82) @(negedge clk);
    Enable = 1'b0;
    repeat (20) @(negedge clk);
    Enable = 1'b1;
    repeat (31) @(negedge clk);
    snap("redrain_continues", 6'b100100);
    repeat (17) @(negedge clk);
    Enable = 1'b0;
    wait_idle();

    // Reset in slot 9, then restart from slot 0
    push(32'hDEAD_BEEF);
    Enable = 1'b1;
    repeat (37) @(negedge clk);
    Rst = 1'b1;
    @(negedge clk);
    snap("reset_mid_frame", 6'b000000);
    push(32'h0000_FFFF);
    sb(32'h0000_FFFF, 1'b0);
    Rst = 1'b0;
    repeat (4) @(negedge clk);
    snap("restart_slot0", 6'b110000);
    repeat (16) @(negedge clk);
    Enable = 1'b0;
    wait_idle();

    // Read lands on the same edge as the slot-1 load
    sb(32'h0, 1'b1); sb(32'h7E81_0042, 1'b0); sb(32'h0, 1'b1);
    Enable = 1'b1;
    repeat (2) @(negedge clk);
    push(32'h7E81_0042);
    repeat (3) @(negedge clk);
    snap("late_read_underrun", 6'b100001);
    repeat (271) @(negedge clk);
    Enable = 1'b0;
    wait_idle();

    repeat (4) @(negedge clk);
    done_req = 1'b1;
  end

endmodule
